// File: rtl/gen_rand_pkg.sv
// Shared constants and helpers for the random-index generator:
// LFSR tap masks, default seed and a one-hot encoder.
package gen_rand_pkg;

   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] TAPS_16      = 16'hB400;

   // Right-shift Galois tap masks for common widths.
   function automatic logic [31:0] lfsr_taps(input int w);
      logic [31:0] t;
      case (w)
         8:       t = 32'h0000_00B8;
         11:      t = 32'h0000_0500;
         12:      t = 32'h0000_0E08;
         13:      t = 32'h0000_1C80;
         14:      t = 32'h0000_3802;
         15:      t = 32'h0000_6000;
         16:      t = {16'h0, TAPS_16};
         17:      t = 32'h0001_2000;
         18:      t = 32'h0002_0400;
         20:      t = 32'h0009_0000;
         24:      t = 32'h00E1_0000;
         32:      t = 32'hA300_0000;
         default: t = {16'h0, TAPS_16};
      endcase
      return t;
   endfunction

   function automatic logic [7:0] onehot(input logic [2:0] idx,
                                         input int n);
      logic [7:0] v;
      v = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < n && idx == 3'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/gen_pseudo_modulus_x_mod_z.sv
// Pseudo-modulus: masks x to the bit length of z-1, then one
// conditional subtract, giving a result in [0, z-1]. Combinational.
// Ports: i_valid_pls/i_x/i_z in; o_valid_pls/o_res/o_z_zero out.
module gen_pseudo_modulus_x_mod_z #(
   parameter int DATA_W = 11
) (
   input  logic              i_valid_pls,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_z,
   output logic              o_valid_pls,
   output logic [DATA_W-1:0] o_res,
   output logic              o_z_zero
);

   logic [DATA_W-1:0] zm1;
   logic [DATA_W-1:0] m;
   logic [DATA_W-1:0] xm;

   always_comb begin
      zm1 = i_z - DATA_W'(1);
      // Smear the MSB of z-1 down to bit 0.
      m = zm1;
      for (int s = 1; s < DATA_W; s = s * 2) begin
         m = m | (m >> s);
      end
      // x & m < 2z, so a single subtract lands below z.
      xm = i_x & m;
      o_z_zero = (i_z == '0);
      if (o_z_zero)     o_res = '0;
      else if (xm >= i_z) o_res = xm - i_z;
      else              o_res = xm;
   end

   assign o_valid_pls = i_valid_pls;

endmodule

// File: rtl/gen_rand_mod_arbiter.sv
// Round-robin shared random-index generator: one grant per cycle,
// LFSR step per grant, pseudo-modulus, result 2 cycles later.
// Ports: clk, rst, i_req, i_z, i_seed_load, i_seed in;
// o_gnt, o_res_valid, o_res, o_z_zero_err, o_busy out.
module gen_rand_mod_arbiter
   import gen_rand_pkg::*;
#(
   parameter int                DATA_W    = 11,
   parameter int                N_REQ     = 4,
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(DEFAULT_SEED)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        i_req,
   input  logic [N_REQ*DATA_W-1:0] i_z,
   input  logic                    i_seed_load,
   input  logic [LFSR_W-1:0]       i_seed,
   output logic [N_REQ-1:0]        o_gnt,
   output logic [N_REQ-1:0]        o_res_valid,
   output logic [DATA_W-1:0]       o_res,
   output logic                    o_z_zero_err,
   output logic                    o_busy
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

   logic [N_REQ-1:0]  pending;
   logic [IDX_W-1:0]  rr_ptr;
   logic [LFSR_W-1:0] lfsr;

   logic              s1_valid;
   logic [IDX_W-1:0]  s1_idx;
   logic [DATA_W-1:0] s1_z;
   logic [DATA_W-1:0] s1_x;

   logic [N_REQ-1:0]  elig;
   logic              win_found;
   logic [IDX_W-1:0]  win_idx;
   logic [DATA_W-1:0] win_z;
   logic [N_REQ-1:0]  win_oh;
   logic [N_REQ-1:0]  s1_oh;
   logic [N_REQ-1:0]  pend_next;
   logic [LFSR_W-1:0] lfsr_next;
   logic [LFSR_W-1:0] seed_val;

   logic              pm_valid;
   logic [DATA_W-1:0] pm_res;
   logic              pm_zero;

   assign elig = i_req & ~pending;

   // Search from rr_ptr+1 upward with wrap; first eligible wins.
   always_comb begin
      int c;
      logic [IDX_W-1:0] ci;
      c = 0;
      ci = '0;
      win_found = 1'b0;
      win_idx = '0;
      for (int off = 1; off <= N_REQ; off++) begin
         c = (int'(rr_ptr) + off) % N_REQ;
         ci = IDX_W'(c);
         if (!win_found && elig[ci]) begin
            win_found = 1'b1;
            win_idx = ci;
         end
      end
   end

   always_comb begin
      win_z = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (win_idx == IDX_W'(k)) win_z = i_z[k*DATA_W +: DATA_W];
      end
   end

   assign win_oh = N_REQ'(onehot(3'(win_idx), N_REQ));
   assign s1_oh  = N_REQ'(onehot(3'(s1_idx), N_REQ));

   assign pend_next = (pending & ~(s1_valid ? s1_oh : '0))
                    | (win_found ? win_oh : '0);

   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
   assign seed_val  = (i_seed == '0) ? LFSR_SEED : i_seed;

   gen_pseudo_modulus_x_mod_z #(
      .DATA_W (DATA_W)
   ) u_pmod (
      .i_valid_pls (s1_valid),
      .i_x         (s1_x),
      .i_z         (s1_z),
      .o_valid_pls (pm_valid),
      .o_res       (pm_res),
      .o_z_zero    (pm_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pending      <= '0;
         rr_ptr       <= IDX_W'(N_REQ - 1);
         lfsr         <= LFSR_SEED;
         s1_valid     <= 1'b0;
         s1_idx       <= '0;
         s1_z         <= '0;
         s1_x         <= '0;
         o_gnt        <= '0;
         o_res_valid  <= '0;
         o_res        <= '0;
         o_z_zero_err <= 1'b0;
      end else begin
         pending      <= pend_next;
         o_gnt        <= win_found ? win_oh : '0;
         s1_valid     <= win_found;
         o_res_valid  <= pm_valid ? s1_oh : '0;
         o_z_zero_err <= pm_valid & pm_zero;
         if (pm_valid) o_res <= pm_res;
         if (win_found) begin
            rr_ptr <= win_idx;
            s1_idx <= win_idx;
            s1_z   <= win_z;
            s1_x   <= lfsr[DATA_W-1:0];
         end
         // A seed load overrides the step; the grant above
         // still captured the pre-load value.
         if (i_seed_load)    lfsr <= seed_val;
         else if (win_found) lfsr <= lfsr_next;
      end
   end

   assign o_busy = |pending;

endmodule

// File: tb/tb_gen_rand_mod_arbiter.sv
// Directed and randomized checks for gen_rand_mod_arbiter.
// Drives all ports; samples outputs 1 time unit after each edge.
module tb_gen_rand_mod_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [43:0] z;
   logic        seed_load;
   logic [15:0] seed;
   logic [3:0]  gnt;
   logic [3:0]  rv;
   logic [10:0] res;
   logic        zerr;
   logic        busy;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   gen_rand_mod_arbiter #(
      .DATA_W    (11),
      .N_REQ     (4),
      .LFSR_W    (16),
      .LFSR_SEED (16'hACE1)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_req        (req),
      .i_z          (z),
      .i_seed_load  (seed_load),
      .i_seed       (seed),
      .o_gnt        (gnt),
      .o_res_valid  (rv),
      .o_res        (res),
      .o_z_zero_err (zerr),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_z(input int k, input logic [10:0] v);
      z[k*11 +: 11] = v;
   endtask

   function automatic logic [10:0] pmod(input logic [10:0] x,
                                        input logic [10:0] zz);
      logic [10:0] m;
      logic [10:0] xm;
      if (zz == 11'd0) return 11'd0;
      m = 11'd0;
      while (m < zz - 11'd1) m = (m << 1) | 11'd1;
      xm = x & m;
      return (xm >= zz) ? xm - zz : xm;
   endfunction

   function automatic logic [15:0] lstep(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
   endfunction

   logic [3:0]  exp_g [6] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h2};
   logic [10:0] exp_r [6] = '{11'd1, 11'd0, 11'd0,
                              11'd4, 11'd6, 11'd0};

   logic [15:0] lm;
   logic [3:0]  g_prev;
   logic [3:0]  reqd;
   logic [10:0] zd [4];
   logic [10:0] zg;
   logic [10:0] er;
   int          k;

   initial begin
      rst = 1'b1; req = '0; z = '0;
      seed_load = 1'b0; seed = '0;
      tick(); tick();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_rv", 32'(rv), 0);
      chk("rst_res", 32'(res), 0);
      chk("rst_zerr", 32'(zerr), 0);
      chk("rst_busy", 32'(busy), 0);
      rst = 1'b0;

      // single request, z=100; seed low bits 0x4E1 & 0x7F = 97
      set_z(0, 11'd100); req = 4'b0001;
      tick();
      chk("s_gnt", 32'(gnt), 32'h1);
      chk("s_busy", 32'(busy), 1);
      chk("s_rv0", 32'(rv), 0);
      req = '0;
      tick();
      chk("s_rv", 32'(rv), 32'h1);
      chk("s_res", 32'(res), 97);
      chk("s_zerr", 32'(zerr), 0);
      chk("s_gnt0", 32'(gnt), 0);
      tick();
      chk("s_rvoff", 32'(rv), 0);
      chk("s_hold", 32'(res), 97);
      chk("s_idle", 32'(busy), 0);

      // all four requesting with z=7 from reset
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) set_z(i, 11'd7);
      req = 4'hF;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(exp_g[i]));
         if (i > 0) begin
            chk($sformatf("rr_rv%0d", i), 32'(rv), 32'(exp_g[i-1]));
            chk($sformatf("rr_res%0d", i), 32'(res), 32'(exp_r[i-1]));
         end
      end
      req = '0;
      tick();
      chk("rr_gnt_end", 32'(gnt), 0);
      chk("rr_rv_end", 32'(rv), 32'h2);
      chk("rr_res_end", 32'(res), 32'(exp_r[5]));
      tick();
      chk("rr_rv_off", 32'(rv), 0);
      chk("rr_idle", 32'(busy), 0);

      // z = 0 on requester 2
      set_z(2, 11'd0); req = 4'b0100;
      tick();
      chk("z0_gnt", 32'(gnt), 32'h4);
      req = '0;
      tick();
      chk("z0_rv", 32'(rv), 32'h4);
      chk("z0_res", 32'(res), 0);
      chk("z0_err", 32'(zerr), 1);
      tick();
      chk("z0_err_off", 32'(zerr), 0);

      // seed load of zero restores default seed
      seed = 16'h0; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("sl_nognt", 32'(gnt), 0);
      set_z(1, 11'd2047); req = 4'b0010;
      tick();
      chk("sl_gnt", 32'(gnt), 32'h2);
      req = '0;
      tick();
      chk("sl_rv", 32'(rv), 32'h2);
      chk("sl_res", 32'(res), 32'h4E1);

      // seed load coincident with a grant: grant uses old value
      seed = 16'h1234; seed_load = 1'b1;
      set_z(0, 11'd2047); req = 4'b0001;
      tick();
      seed_load = 1'b0;
      chk("slg_gnt", 32'(gnt), 32'h1);
      req = 4'b0010;
      tick();
      chk("slg_rv0", 32'(rv), 32'h1);
      chk("slg_res0", 32'(res), 32'h270);
      chk("slg_gnt1", 32'(gnt), 32'h2);
      req = '0;
      tick();
      chk("slg_rv1", 32'(rv), 32'h2);
      chk("slg_res1", 32'(res), 32'h234);

      // reset while a result is in flight
      req = 4'b0010;
      tick();
      chk("mr_gnt", 32'(gnt), 32'h2);
      req = '0; rst = 1'b1;
      tick();
      chk("mr_rv", 32'(rv), 0);
      chk("mr_gnt0", 32'(gnt), 0);
      chk("mr_res", 32'(res), 0);
      chk("mr_busy", 32'(busy), 0);
      rst = 1'b0;
      tick();
      chk("mr_norv", 32'(rv), 0);
      set_z(3, 11'd2047); req = 4'b1010;
      tick();
      chk("mr_ptr", 32'(gnt), 32'h2);
      req = '0;
      tick();
      chk("mr_rv2", 32'(rv), 32'h2);
      chk("mr_lfsr", 32'(res), 32'h4E1);
      tick();

      // random regression against a model
      rst = 1'b1; tick(); rst = 1'b0;
      lm = 16'hACE1; g_prev = '0; zg = 11'd1; er = '0;
      for (int n = 0; n < 10000; n++) begin
         reqd = 4'($urandom);
         req = reqd;
         for (int j = 0; j < 4; j++) begin
            zd[j] = 11'($urandom_range(1, 2047));
            set_z(j, zd[j]);
         end
         tick();
         chk("rg_rv", 32'(rv), 32'(g_prev));
         chk("rg_zerr", 32'(zerr), 0);
         if (g_prev != 4'h0) begin
            chk("rg_res", 32'(res), 32'(er));
            chk("rg_lt_z", 32'(res < zg), 1);
         end
         chk("rg_grant_when_elig", 32'(gnt != 4'h0),
             32'((reqd & ~g_prev) != 4'h0));
         if (gnt != 4'h0) begin
            chk("rg_onehot", 32'($onehot(gnt)), 1);
            chk("rg_not_pend", 32'(gnt & g_prev), 0);
            chk("rg_req", 32'(gnt & ~reqd), 0);
            k = 0;
            for (int j = 0; j < 4; j++) if (gnt[j]) k = j;
            zg = zd[k];
            er = pmod(lm[10:0], zg);
            lm = lstep(lm);
         end
         g_prev = gnt;
      end
      req = '0;
      tick();
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
